// File: rtl/regfile_writeback.sv
// Integer register file writer: merges ALU results and buffered load results onto one write port, tracks pending writes.
// Latency: 1 cycle from selection to write_enable; a load is selectable the cycle after it is pushed.
// Backpressure: alu_ready only while the load FIFO is empty; ld_ready while the FIFO is not full. Optional macro WB_FORWARD_EN adds fwd_* bypass outputs.
module regfile_writeback #(
  parameter int XLEN          = 32,
  parameter int LD_FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_addr_lo,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic [31:0]     busy,
  output logic            write_enable,
  output logic [4:0]      write_addr,
`ifdef WB_FORWARD_EN
  output logic [XLEN-1:0] write_data,
  output logic            fwd_valid,
  output logic [4:0]      fwd_addr,
  output logic [XLEN-1:0] fwd_data
`else
  output logic [XLEN-1:0] write_data
`endif
);

  localparam int PTR_W = (LD_FIFO_DEPTH > 1) ? $clog2(LD_FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // One buffered or selected write: destination and final value.
  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } entry_t;

  // Load FIFO state.
  entry_t             fifo_mem [LD_FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  logic               push;
  logic               pop;
  logic               fifo_empty;
  logic               fifo_full;
  entry_t             push_entry;
  logic [XLEN-1:0]    ld_ext;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;

  // Arbitration result.
  logic               sel_valid;
  entry_t             sel_entry;

  logic [31:0]        busy_next;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(LD_FIFO_DEPTH));

  // Ready signals depend only on the registered count, never on the valids.
  assign ld_ready  = !fifo_full;
  assign alu_ready = fifo_empty;

  assign push = ld_valid && ld_ready;
  // The head always drains when present; the register file never stalls us.
  assign pop  = !fifo_empty;

  // Extract the addressed byte/half and extend it so the FIFO holds final values.
  always_comb begin
    ld_byte = ld_data[{ld_addr_lo, 3'b000} +: 8];
    ld_half = ld_data[{ld_addr_lo[1], 4'b0000} +: 16];
    ld_ext  = ld_data;
    case (ld_funct3)
      F3_LB:   ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      F3_LBU:  ld_ext = {{(XLEN-8){1'b0}}, ld_byte};
      F3_LH:   ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
      F3_LHU:  ld_ext = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_ext = ld_data;
    endcase
    push_entry.rd   = ld_rd;
    push_entry.data = ld_ext;
  end

  // Load storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= push_entry;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop keeps count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Loads first so the FIFO drains; the ALU only wins when the FIFO is empty.
  always_comb begin
    sel_valid = 1'b0;
    sel_entry = '0;
    if (pop) begin
      sel_valid = 1'b1;
      sel_entry = fifo_mem[rd_ptr];
    end else if (alu_valid) begin
      sel_valid      = 1'b1;
      sel_entry.rd   = alu_rd;
      sel_entry.data = alu_data;
    end
  end

  // Pending-write bits: clear on selection, then set on issue so a new issue wins.
  always_comb begin
    busy_next = busy;
    if (sel_valid) begin
      busy_next[sel_entry.rd] = 1'b0;
    end
    if (issue_valid && (issue_rd != 5'd0)) begin
      busy_next[issue_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // Registered write port; address and data hold when nothing is written.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
    end else if (sel_valid && (sel_entry.rd != 5'd0)) begin
      write_enable <= 1'b1;
      write_addr   <= sel_entry.rd;
      write_data   <= sel_entry.data;
    end else begin
      write_enable <= 1'b0;
    end
  end

`ifdef WB_FORWARD_EN
  // Bypass copy of this cycle's selection, one cycle ahead of the write port.
  assign fwd_valid = sel_valid && (sel_entry.rd != 5'd0);
  assign fwd_addr  = sel_entry.rd;
  assign fwd_data  = sel_entry.data;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed and random checks of regfile_writeback against a queue-based reference model.
module tb_regfile_writeback;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_valid;
  logic            ld_ready;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;
  logic [2:0]      ld_funct3;
  logic [1:0]      ld_addr_lo;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic [31:0]     busy;
  logic            write_enable;
  logic [4:0]      write_addr;
  logic [XLEN-1:0] write_data;
`ifdef WB_FORWARD_EN
  logic            fwd_valid;
  logic [4:0]      fwd_addr;
  logic [XLEN-1:0] fwd_data;
`endif

  regfile_writeback #(.XLEN(XLEN), .LD_FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_rd        (ld_rd),
    .ld_data      (ld_data),
    .ld_funct3    (ld_funct3),
    .ld_addr_lo   (ld_addr_lo),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .busy         (busy),
    .write_enable (write_enable),
    .write_addr   (write_addr),
`ifdef WB_FORWARD_EN
    .write_data   (write_data),
    .fwd_valid    (fwd_valid),
    .fwd_addr     (fwd_addr),
    .fwd_data     (fwd_data)
`else
    .write_data   (write_data)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] v;
  } ent_t;

  // Reference model state: pending loads in arrival order, pending bits, last write.
  ent_t        mq[$];
  logic [31:0] m_busy;
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Load result as architecturally defined: shift down to the addressed byte/half, mask, extend.
  function automatic logic [31:0] ext_model(input logic [31:0] d, input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] v;
    case (f3)
      3'd0: begin v = (d >> (8 * off)) & 32'hFF;  if (v >= 32'd128)   v = v + 32'hFFFF_FF00; end
      3'd4: v = (d >> (8 * off)) & 32'hFF;
      3'd1: begin v = (d >> (16 * off[1])) & 32'hFFFF; if (v >= 32'd32768) v = v + 32'hFFFF_0000; end
      3'd5: v = (d >> (16 * off[1])) & 32'hFFFF;
      default: v = d;
    endcase
    return v;
  endfunction

  // One clock cycle: check ready outputs against the model, advance the model, then check registered outputs.
  task automatic tick();
    ent_t s;
    bit   have;
    bit   ldr;
    #1;
    have = 0;
    s.rd = '0;
    s.v  = '0;
    if (reset) begin
      mq.delete();
      m_busy = '0;
      m_we   = 1'b0;
      m_wa   = '0;
      m_wd   = '0;
    end else begin
      ldr = (mq.size() != DEPTH);
      chk("alu_ready", alu_ready, mq.size() == 0);
      chk("ld_ready", ld_ready, ldr);
      if (mq.size() > 0) begin
        s = mq.pop_front();
        have = 1;
      end else if (alu_valid) begin
        s.rd = alu_rd;
        s.v  = alu_data;
        have = 1;
      end
`ifdef WB_FORWARD_EN
      chk("fwd_valid", fwd_valid, have && s.rd != 0);
      if (have && s.rd != 0) begin
        chk("fwd_addr", fwd_addr, s.rd);
        chk("fwd_data", fwd_data, s.v);
      end
`endif
      if (ld_valid && ldr) mq.push_back('{rd: ld_rd, v: ext_model(ld_data, ld_funct3, ld_addr_lo)});
      if (have) m_busy[s.rd] = 1'b0;
      if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      if (have && s.rd != 0) begin
        m_we = 1'b1;
        m_wa = s.rd;
        m_wd = s.v;
      end else begin
        m_we = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("write_enable", write_enable, m_we);
    chk("write_addr", write_addr, m_wa);
    chk("write_data", write_data, m_wd);
    chk("busy", busy, m_busy);
  endtask

  task automatic idle();
    reset       = 1'b0;
    alu_valid   = 1'b0;
    alu_rd      = '0;
    alu_data    = '0;
    ld_valid    = 1'b0;
    ld_rd       = '0;
    ld_data     = '0;
    ld_funct3   = '0;
    ld_addr_lo  = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
  endtask

  task automatic push_ld(input logic [4:0] rd, input logic [31:0] d, input logic [2:0] f3, input logic [1:0] off);
    ld_valid   = 1'b1;
    ld_rd      = rd;
    ld_data    = d;
    ld_funct3  = f3;
    ld_addr_lo = off;
  endtask

  logic [31:0] ext_exp [4];
  logic [4:0]  prio_exp [5];

  initial begin
    ext_exp[0] = 32'hFFFF_FF80;
    ext_exp[1] = 32'h0000_00FF;
    ext_exp[2] = 32'hFFFF_80FF;
    ext_exp[3] = 32'h0000_7F01;
    prio_exp[0] = 5'd1; prio_exp[1] = 5'd2; prio_exp[2] = 5'd3; prio_exp[3] = 5'd4; prio_exp[4] = 5'd9;

    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    tick();
    chk("rst_we", write_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wdata", write_data, 0);
    idle();
    #1;
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_alu_ready", alu_ready, 1);

    // ALU path with a pending write on x5.
    issue_valid = 1'b1; issue_rd = 5'd5;
    tick();
    chk("alu_busy5_set", busy[5], 1);
    idle();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    #1;
    chk("alu_ready_idle", alu_ready, 1);
    tick();
    chk("alu_we", write_enable, 1);
    chk("alu_waddr", write_addr, 5);
    chk("alu_wdata", write_data, 32'h1234);
    chk("alu_busy5_clr", busy[5], 0);
    idle();

    // Load extension variants, one push per cycle, each written a cycle after it is buffered.
    for (int i = 0; i < 5; i++) begin
      idle();
      case (i)
        0: push_ld(5'd10, 32'h80FF_7F01, 3'b000, 2'd3);
        1: push_ld(5'd11, 32'h80FF_7F01, 3'b100, 2'd2);
        2: push_ld(5'd12, 32'h80FF_7F01, 3'b001, 2'd2);
        3: push_ld(5'd13, 32'h80FF_7F01, 3'b101, 2'd0);
        default: ;
      endcase
      tick();
      if (i >= 1) begin
        chk("ext_we", write_enable, 1);
        chk("ext_data", write_data, ext_exp[i-1]);
      end
    end
    idle();
    tick();

    // Loads keep priority over a held ALU result, which writes only after the FIFO drains.
    for (int i = 0; i < 6; i++) begin
      idle();
      if (i < 4) push_ld(5'(i + 1), 32'h100 + i, 3'b010, 2'd0);
      if (i >= 1) begin
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
      end
      #1;
      if (i >= 1 && i <= 4) chk("prio_alu_blocked", alu_ready, 0);
      tick();
      if (i >= 1) chk("prio_order", write_addr, prio_exp[i-1]);
    end
    idle();
    tick();

    // x0: accepted but never written, and never marked busy.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
    issue_valid = 1'b1; issue_rd = 5'd0;
    #1;
    chk("x0_alu_ready", alu_ready, 1);
    tick();
    chk("x0_we", write_enable, 0);
    chk("x0_busy", busy, 0);
    idle();

    // Same-cycle clear and set on x7: the new issue keeps the bit.
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    idle();
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h7777;
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    chk("race_busy7", busy[7], 1);
    chk("race_we", write_enable, 1);
    chk("race_waddr", write_addr, 7);
    idle();
    tick();

    // Reset mid-stream drops the buffered load and all pending bits.
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h1;
    tick();
    idle();
    for (int r = 1; r <= 3; r++) begin
      idle();
      issue_valid = 1'b1; issue_rd = 5'(r);
      if (r == 3) push_ld(5'd6, 32'hCAFE_F00D, 3'b010, 2'd0);
      tick();
    end
    chk("mid_busy", busy, 32'h0000_000E);
    idle();
    reset = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h4444;
    tick();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_we", write_enable, 0);
    idle();
    #1;
    chk("mid_rst_ld_ready", ld_ready, 1);
    chk("mid_rst_alu_ready", alu_ready, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mid_no_stale", write_enable, 0);
    end

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      idle();
      reset       = ($urandom_range(0, 49) == 0);
      alu_valid   = ($urandom_range(0, 1) == 1);
      alu_rd      = 5'($urandom_range(0, 31));
      alu_data    = $urandom;
      ld_valid    = ($urandom_range(0, 9) < 4);
      ld_rd       = 5'($urandom_range(0, 31));
      ld_data     = $urandom;
      ld_funct3   = 3'($urandom_range(0, 7));
      ld_addr_lo  = 2'($urandom_range(0, 3));
      issue_valid = ($urandom_range(0, 9) < 3);
      issue_rd    = 5'($urandom_range(0, 31));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
